// File: rtl/data_mem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus a small MMIO page
// holding GPIO out/in and a compare timer with a pending flag.
module data_mem_mmio #(
    parameter int DEPTH_WORDS = 64,
    parameter int GPIO_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memWrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq,
    output logic              addr_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [31:0] A_GOUT = 32'hFFFF_FF00;
    localparam logic [31:0] A_GIN  = 32'hFFFF_FF04;
    localparam logic [31:0] A_CNT  = 32'hFFFF_FF08;
    localparam logic [31:0] A_CMP  = 32'hFFFF_FF0C;
    localparam logic [31:0] A_CTRL = 32'hFFFF_FF10;

    logic [31:0]       r_mem [DEPTH_WORDS];
    logic [GPIO_W-1:0] r_gpio_out;
    logic [GPIO_W-1:0] r_sync1;
    logic [GPIO_W-1:0] r_sync2;
    logic [31:0]       r_cnt;
    logic [31:0]       r_cmp;
    logic              r_en;
    logic              r_ar;
    logic              r_pend;

    logic              w_aligned;
    logic              w_sel_ram;
    logic              w_sel_gout;
    logic              w_sel_gin;
    logic              w_sel_cnt;
    logic              w_sel_cmp;
    logic              w_sel_ctrl;
    logic              w_match;
    logic [AW-1:0]     w_idx;
    logic [31:0]       w_rdata;

    assign w_aligned  = (addr[1:0] == 2'b00);
    assign w_sel_ram  = w_aligned && (addr[31:AW+2] == '0);
    assign w_sel_gout = (addr == A_GOUT);
    assign w_sel_gin  = (addr == A_GIN);
    assign w_sel_cnt  = (addr == A_CNT);
    assign w_sel_cmp  = (addr == A_CMP);
    assign w_sel_ctrl = (addr == A_CTRL);
    assign w_idx      = addr[AW+1:2];

    assign addr_err = !(w_sel_ram || w_sel_gout || w_sel_gin ||
                        w_sel_cnt || w_sel_cmp || w_sel_ctrl);

    // Match only counts while enabled; EN sampled before any CTRL write lands
    assign w_match = r_en && (r_cnt == r_cmp);

    always_comb begin
        w_rdata = '0;
        unique case (1'b1)
            w_sel_ram:  w_rdata = r_mem[w_idx];
            w_sel_gout: w_rdata = 32'(r_gpio_out);
            w_sel_gin:  w_rdata = 32'(r_sync2);
            w_sel_cnt:  w_rdata = r_cnt;
            w_sel_cmp:  w_rdata = r_cmp;
            w_sel_ctrl: w_rdata = {29'd0, r_pend, r_ar, r_en};
            default:    w_rdata = '0;
        endcase
    end

    assign readData  = w_rdata;
    assign gpio_out  = r_gpio_out;
    assign timer_irq = r_pend;

    // RAM has no reset; contents are undefined until written
    always_ff @(posedge clk) begin
        if (memWrite && w_sel_ram) begin
            r_mem[w_idx] <= writeData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_cnt      <= '0;
            r_cmp      <= 32'hFFFF_FFFF;
            r_en       <= 1'b0;
            r_ar       <= 1'b0;
            r_pend     <= 1'b0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            if (memWrite && w_sel_gout) begin
                r_gpio_out <= writeData[GPIO_W-1:0];
            end
            if (memWrite && w_sel_cmp) begin
                r_cmp <= writeData;
            end
            if (memWrite && w_sel_ctrl) begin
                r_en <= writeData[0];
                r_ar <= writeData[1];
            end
            if (memWrite && w_sel_cnt) begin
                r_cnt <= writeData;
            end else if (r_en) begin
                r_cnt <= (w_match && r_ar) ? 32'd0 : r_cnt + 32'd1;
            end
            // A match in the clear cycle keeps the flag set
            if (w_match) begin
                r_pend <= 1'b1;
            end else if (memWrite && w_sel_ctrl && writeData[2]) begin
                r_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio: vector table for RAM/decode,
// hand sequences for GPIO sync, timer, collisions and async reset.
module tb_data_mem_mmio;

    localparam logic [31:0] A_GOUT = 32'hFFFF_FF00;
    localparam logic [31:0] A_GIN  = 32'hFFFF_FF04;
    localparam logic [31:0] A_CNT  = 32'hFFFF_FF08;
    localparam logic [31:0] A_CMP  = 32'hFFFF_FF0C;
    localparam logic [31:0] A_CTRL = 32'hFFFF_FF10;

    logic        clk;
    logic        reset;
    logic        memWrite;
    logic [31:0] addr;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        timer_irq;
    logic        addr_err;

    int total = 0;
    int bad   = 0;

    data_mem_mmio #(.DEPTH_WORDS(64), .GPIO_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .memWrite(memWrite),
        .addr(addr),
        .writeData(writeData),
        .readData(readData),
        .gpio_in(gpio_in),
        .gpio_out(gpio_out),
        .timer_irq(timer_irq),
        .addr_err(addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] rd;
        logic        err;
        bit          chk_rd;
    } exp_t;

    typedef struct {
        string       nm;
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        bit          chk_rd;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic sb_pop();
        exp_t e;
        e = sbq.pop_front();
        if (e.chk_rd) chk(e.nm, readData, e.rd);
        chk({e.nm, "_err"}, 32'(addr_err), 32'(e.err));
    endtask

    function automatic vec_t mk(string nm, bit we, logic [31:0] a,
                                logic [31:0] wd, logic [31:0] rd,
                                logic err, bit chk_rd);
        vec_t v;
        v.nm = nm; v.we = we; v.a = a; v.wd = wd;
        v.rd = rd; v.err = err; v.chk_rd = chk_rd;
        return v;
    endfunction

    task automatic rd_chk(input string nm, input logic [31:0] a,
                          input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        memWrite = 1'b0;
        addr     = a;
        e.nm = nm; e.rd = exp; e.err = 1'b0; e.chk_rd = 1'b1;
        sbq.push_back(e);
        #1;
        sb_pop();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        memWrite  = 1'b1;
        addr      = a;
        writeData = d;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset     = 1'b0;
        memWrite  = 1'b0;
        addr      = '0;
        writeData = '0;
        gpio_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gpio_out", 32'(gpio_out), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        vt.push_back(mk("w10", 1, 32'h10, 32'hDEADBEEF, 0, 0, 0));
        vt.push_back(mk("r10", 0, 32'h10, 0, 32'hDEADBEEF, 0, 1));
        vt.push_back(mk("w14", 1, 32'h14, 32'h1, 0, 0, 0));
        vt.push_back(mk("r14", 0, 32'h14, 0, 32'h1, 0, 1));
        vt.push_back(mk("rcmp", 0, A_CMP, 0, 32'hFFFFFFFF, 0, 1));
        vt.push_back(mk("wmis", 1, 32'h12, 32'h12345678, 0, 1, 1));
        vt.push_back(mk("r10b", 0, 32'h10, 0, 32'hDEADBEEF, 0, 1));
        vt.push_back(mk("runm", 0, 32'h80000000, 0, 0, 1, 1));
        vt.push_back(mk("rmis", 0, 32'h11, 0, 0, 1, 1));
        vt.push_back(mk("rpast", 0, 32'h100, 0, 0, 1, 1));
        vt.push_back(mk("wtop", 1, 32'hFC, 32'hCAFEF00D, 0, 0, 0));
        vt.push_back(mk("rtop", 0, 32'hFC, 0, 32'hCAFEF00D, 0, 1));
        vt.push_back(mk("wold", 1, 32'h10, 32'h11111111, 32'hDEADBEEF, 0, 1));
        vt.push_back(mk("rnew", 0, 32'h10, 0, 32'h11111111, 0, 1));
        vt.push_back(mk("wgo", 1, A_GOUT, 32'hA5, 32'h0, 0, 1));
        vt.push_back(mk("rgo", 0, A_GOUT, 0, 32'hA5, 0, 1));
        vt.push_back(mk("wgi", 1, A_GIN, 32'hFF, 32'h0, 0, 1));
        vt.push_back(mk("rgi", 0, A_GIN, 0, 32'h0, 0, 1));
        vt.push_back(mk("rhole", 0, 32'hFFFFFF14, 0, 0, 1, 1));
        vt.push_back(mk("rctrl", 0, A_CTRL, 0, 32'h0, 0, 1));
        vt.push_back(mk("rcnt", 0, A_CNT, 0, 32'h0, 0, 1));

        foreach (vt[i]) begin
            @(negedge clk);
            memWrite  = vt[i].we;
            addr      = vt[i].a;
            writeData = vt[i].wd;
            e.nm = vt[i].nm; e.rd = vt[i].rd;
            e.err = vt[i].err; e.chk_rd = vt[i].chk_rd;
            sbq.push_back(e);
            #1;
            sb_pop();
        end
        @(negedge clk);
        memWrite = 1'b0;
        #1;
        chk("gpio_out", 32'(gpio_out), 32'hA5);

        // GPIO input: new value visible after two edges
        @(negedge clk);
        addr    = A_GIN;
        gpio_in = 8'h3C;
        e.nm = "gin0"; e.rd = 32'h0; e.err = 1'b0; e.chk_rd = 1'b1;
        sbq.push_back(e);
        #1;
        sb_pop();
        rd_chk("gin1", A_GIN, 32'h0);
        rd_chk("gin2", A_GIN, 32'h3C);

        // One-shot timer
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 8; i++) begin
            rd_chk($sformatf("os_cnt%0d", i), A_CNT, 32'(i));
            chk($sformatf("os_irq%0d", i), 32'(timer_irq), 32'(i >= 6));
        end
        wr(A_CTRL, 32'h5);
        rd_chk("os_clr_cnt", A_CNT, 32'd9);
        chk("os_clr_irq", 32'(timer_irq), 32'h0);
        wr(A_CTRL, 32'h0);
        rd_chk("hold_a", A_CNT, 32'd11);
        rd_chk("hold_b", A_CNT, 32'd11);

        // Auto-reload
        wr(A_CNT, 32'd0);
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h3);
        for (int i = 0; i < 11; i++) begin
            rd_chk($sformatf("ar_cnt%0d", i), A_CNT, 32'(i % 4));
            chk($sformatf("ar_irq%0d", i), 32'(timer_irq), 32'(i >= 4));
        end
        // Clear in the match cycle: set wins
        wr(A_CTRL, 32'h7);
        rd_chk("col_cnt", A_CNT, 32'd0);
        chk("col_irq", 32'(timer_irq), 32'h1);
        wr(A_CTRL, 32'h7);
        rd_chk("clr_cnt", A_CNT, 32'd2);
        chk("clr_irq", 32'(timer_irq), 32'h0);
        rd_chk("re_cnt3", A_CNT, 32'd3);
        chk("re_irq3", 32'(timer_irq), 32'h0);
        rd_chk("re_cnt0", A_CNT, 32'd0);
        chk("re_irq0", 32'(timer_irq), 32'h1);

        // CNT write beats increment
        wr(A_CNT, 32'h100);
        rd_chk("wcnt_a", A_CNT, 32'h100);
        rd_chk("wcnt_b", A_CNT, 32'h101);

        // Wrap
        wr(A_CMP, 32'h10);
        wr(A_CNT, 32'hFFFFFFFE);
        rd_chk("wrap_a", A_CNT, 32'hFFFFFFFE);
        rd_chk("wrap_b", A_CNT, 32'hFFFFFFFF);
        rd_chk("wrap_c", A_CNT, 32'h0);
        rd_chk("wrap_d", A_CNT, 32'h1);

        // Async reset mid-count
        chk("pre_irq", 32'(timer_irq), 32'h1);
        chk("pre_gpio", 32'(gpio_out), 32'hA5);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_irq", 32'(timer_irq), 32'h0);
        chk("ar_gpio", 32'(gpio_out), 32'h0);
        addr = A_CNT;
        #1;
        chk("ar_cnt", readData, 32'h0);
        addr = A_CMP;
        #1;
        chk("ar_cmp", readData, 32'hFFFFFFFF);
        addr = A_CTRL;
        #1;
        chk("ar_ctrl", readData, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rd_chk("post_cnt", A_CNT, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
- Data-side memory subsystem directly downstream of the single-cycle MIPS core.
- Consumes the core's ALU result (address), store data and memWrite, and returns readData in the same cycle.
- Contains word-addressed data RAM plus a small memory-mapped peripheral page: GPIO output register, synchronized GPIO input, and a compare timer with an interrupt flag.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; power of two, 16..4096.
- GPIO_W, 8, width of the GPIO in/out ports (1..32).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- memWrite  input  1  store strobe from the core.
- addr  input  32  byte address (the core's ALU output).
- writeData  input  32  store data.
- readData  output  32  load data; combinational from addr.
- gpio_in  input  GPIO_W  external asynchronous inputs.
- gpio_out  output  GPIO_W  registered GPIO output.
- timer_irq  output  1  registered timer interrupt-pending flag.
- addr_err  output  1  combinational flag for a misaligned or unmapped access.

Behaviour:
- Address map (word aligned):
  - RAM at 0 .. DEPTH_WORDS*4-1, indexed by addr[log2(DEPTH_WORDS)+1:2].
  - 0xFFFF_FF00 GPIO_OUT, read/write, low GPIO_W bits.
  - 0xFFFF_FF04 GPIO_IN, read-only.
  - 0xFFFF_FF08 TIMER_CNT, read/write.
  - 0xFFFF_FF0C TIMER_CMP, read/write.
  - 0xFFFF_FF10 TIMER_CTRL: bit0 EN, bit1 AUTORELOAD, bit2 PEND (write 1 to clear).
- Unused register bits read 0.
- Reads are combinational, zero latency, so a load completes in the core's single cycle.
- Writes take effect on the rising clk edge when memWrite=1.
- A same-cycle read of the word being written returns the old value.
- addr_err=1 when addr[1:0]!=0 or addr is outside both regions:
  - readData=0.
  - Any write is suppressed.
  - addr_err is asserted regardless of memWrite.
- Writes to GPIO_IN are ignored, with addr_err=0.
- Reset (reset=0, async):
  - gpio_out=0, timer_irq=0, CNT=0, CMP=0xFFFF_FFFF, CTRL=0.
  - Synchronizer flops are cleared.
  - RAM is not reset; its contents are undefined until written.
  - Reset asserted mid-operation clears all registers immediately. RAM writes that cycle are not guaranteed.
- GPIO_IN path:
  - gpio_in passes through a 2-flop synchronizer; the GPIO_IN read returns the second stage.
  - A change on gpio_in is visible to reads 2 clk edges later.
- Timer operation, each cycle with EN=1:
  - If CNT==CMP:
    - PEND<=1.
    - CNT<=0 if AUTORELOAD=1; otherwise CNT<=CNT+1.
  - Otherwise CNT<=CNT+1.
  - CNT increments modulo 2^32 (0xFFFF_FFFF wraps to 0).
- With EN=0, CNT holds and no match is evaluated.
- Simultaneous events:
  - A core write to TIMER_CNT overrides the increment/reload that cycle.
  - A match in the same cycle as a PEND write-1-clear leaves PEND=1 (set wins).
  - A write to TIMER_CTRL updates EN/AUTORELOAD for the next cycle. The match in the write cycle is evaluated with the old EN.
- timer_irq equals PEND (registered, no combinational path from addr).

Test Plan:
- Reset then RAM: hold reset=0 for 3 cycles, release.
  - Expect gpio_out=0, timer_irq=0, readData@0xFFFF_FF0C=0xFFFF_FFFF.
  - Store 0xDEADBEEF @0x10, then load 0x10 → 0xDEADBEEF.
  - Load @0x14 after storing 0x1 → 0x00000001.
- Errors: store 0x12345678 @0x12 (misaligned) → addr_err=1, and word @0x10 unchanged.
  - Load @0x8000_0000 → readData=0, addr_err=1.
- GPIO:
  - Store 0xA5 @0xFFFF_FF00 → gpio_out=0xA5 after the edge.
  - Drive gpio_in=0x3C → reads of 0xFFFF_FF04 give the old value for 2 edges, then 0x3C.
- Timer one-shot: CMP=5, CTRL=0x1.
  - timer_irq rises the edge after CNT reaches 5, and CNT continues to 6, 7, ...
  - Write CTRL=0x5 → timer_irq=0 next cycle.
- Timer auto-reload and wrap:
  - CMP=3, CTRL=0x3 → CNT sequence 0,1,2,3,0,1...; PEND set on each 3.
  - Separately, CNT=0xFFFF_FFFE, CMP=0x10, EN=1 → CNT wraps 0xFFFF_FFFF→0.
- Collisions:
  - A CNT write in the same cycle as an increment → written value wins.
  - A PEND clear in the same cycle as a match → timer_irq stays 1.
  - Assert reset mid-count → CNT=0 and timer_irq=0 asynchronously.
